// File: rtl/regfile_rename.sv
// Architectural register file with a per-register rename (busy/tag) table.
// Dispatch reads a value, or the ROB tag that will produce it. Dispatch
// claims a destination register with a ROB tag. Commit writes the value back
// and releases the claim only when the committing tag still owns it. A flush
// drops every pending claim at once.
module regfile_rename #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int AW    = 5,
   parameter int NREAD = 2,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic                   flush,
   input  logic                   issue_en,
   input  logic [AW-1:0]          issue_rd,
   input  logic [TAG_W-1:0]       issue_tag,
   input  logic                   commit_en,
   input  logic [AW-1:0]          commit_rd,
   input  logic [TAG_W-1:0]       commit_tag,
   input  logic [XLEN-1:0]        commit_data,
   input  logic [NREAD*AW-1:0]    rd_addr,
   output logic [NREAD*XLEN-1:0]  rd_data,
   output logic [NREAD-1:0]       rd_busy,
   output logic [NREAD*TAG_W-1:0] rd_tag
);

   // Flattened view of every register's state, used by the read ports.
   logic [XLEN-1:0]  data_all [NREG];
   logic             busy_all [NREG];
   logic [TAG_W-1:0] tag_all  [NREG];

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            // Register 0 is hard-wired: never written, never busy.
            assign data_all[gi] = '0;
            assign busy_all[gi] = 1'b0;
            assign tag_all[gi]  = '0;
         end else begin : g_live
            localparam logic [AW-1:0] IDX = AW'(gi);

            logic [XLEN-1:0]  data_reg;
            logic             busy_reg;
            logic [TAG_W-1:0] tag_reg;
            logic             commit_hit;
            logic             issue_hit;
            logic             tag_match;

            assign commit_hit = commit_en && (commit_rd == IDX);
            assign issue_hit  = issue_en && (issue_rd == IDX);
            assign tag_match  = busy_reg && (tag_reg == commit_tag);

            // Commit writes the value unconditionally; commit order is architectural order.
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  data_reg <= '0;
               end else if (rdy && commit_hit) begin
                  data_reg <= commit_data;
               end
            end

            // Claim tracking: flush beats issue, issue beats a same-cycle release.
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  busy_reg <= 1'b0;
                  tag_reg  <= '0;
               end else if (rdy) begin
                  if (flush) begin
                     busy_reg <= 1'b0;
                  end else if (issue_hit) begin
                     busy_reg <= 1'b1;
                     tag_reg  <= issue_tag;
                  end else if (commit_hit && tag_match) begin
                     busy_reg <= 1'b0;
                  end
               end
            end

            assign data_all[gi] = data_reg;
            assign busy_all[gi] = busy_reg;
            assign tag_all[gi]  = tag_reg;
         end
      end
   endgenerate

   genvar gk;
   generate
      for (gk = 0; gk < NREAD; gk++) begin : g_port
         logic [AW-1:0]    addr;
         logic [XLEN-1:0]  data_out;
         logic             busy_out;
         logic [TAG_W-1:0] tag_out;

         // Combinational read with commit bypass; the same-cycle issue is not visible.
         always_comb begin
            addr     = rd_addr[gk*AW +: AW];
            data_out = data_all[addr];
            busy_out = busy_all[addr];
            tag_out  = busy_all[addr] ? tag_all[addr] : '0;
            if (addr == '0) begin
               data_out = '0;
               busy_out = 1'b0;
               tag_out  = '0;
            end else if (commit_en && (commit_rd == addr) &&
                         (!busy_all[addr] || (tag_all[addr] == commit_tag))) begin
               data_out = commit_data;
               busy_out = 1'b0;
               tag_out  = '0;
            end
         end

         assign rd_data[gk*XLEN +: XLEN]   = data_out;
         assign rd_busy[gk]                = busy_out;
         assign rd_tag[gk*TAG_W +: TAG_W]  = tag_out;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_rename.sv
// Directed, table-driven bench for regfile_rename: each vector drives one
// cycle of issue/commit/flush traffic, checks the combinational reads in that
// cycle, and lets the clock edge update state for the next vector.
module tb_regfile_rename;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int AW    = 5;
   localparam int NREAD = 2;
   localparam int TAG_W = 4;

   logic                   clk;
   logic                   rst;
   logic                   rdy;
   logic                   flush;
   logic                   issue_en;
   logic [AW-1:0]          issue_rd;
   logic [TAG_W-1:0]       issue_tag;
   logic                   commit_en;
   logic [AW-1:0]          commit_rd;
   logic [TAG_W-1:0]       commit_tag;
   logic [XLEN-1:0]        commit_data;
   logic [NREAD*AW-1:0]    rd_addr;
   logic [NREAD*XLEN-1:0]  rd_data;
   logic [NREAD-1:0]       rd_busy;
   logic [NREAD*TAG_W-1:0] rd_tag;

   int checks;
   int failures;

   regfile_rename #(
      .XLEN(XLEN), .NREG(NREG), .AW(AW), .NREAD(NREAD), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .issue_en(issue_en), .issue_rd(issue_rd), .issue_tag(issue_tag),
      .commit_en(commit_en), .commit_rd(commit_rd), .commit_tag(commit_tag),
      .commit_data(commit_data), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .rd_tag(rd_tag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic             rdy;
      logic             flush;
      logic             ie;
      logic [AW-1:0]    ird;
      logic [TAG_W-1:0] itag;
      logic             ce;
      logic [AW-1:0]    crd;
      logic [TAG_W-1:0] ctag;
      logic [XLEN-1:0]  cdata;
      logic [AW-1:0]    a0;
      logic [AW-1:0]    a1;
      logic [XLEN-1:0]  d0;
      logic             b0;
      logic [TAG_W-1:0] t0;
      logic [XLEN-1:0]  d1;
      logic             b1;
      logic [TAG_W-1:0] t1;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic rdy_i, input logic fl, input logic ie, input int ird, input int itag,
      input logic ce, input int crd, input int ctag, input logic [XLEN-1:0] cdata,
      input int a0, input int a1,
      input logic [XLEN-1:0] d0, input logic b0, input int t0,
      input logic [XLEN-1:0] d1, input logic b1, input int t1);
      vec_t v;
      v.rdy = rdy_i; v.flush = fl;
      v.ie = ie; v.ird = AW'(ird); v.itag = TAG_W'(itag);
      v.ce = ce; v.crd = AW'(crd); v.ctag = TAG_W'(ctag); v.cdata = cdata;
      v.a0 = AW'(a0); v.a1 = AW'(a1);
      v.d0 = d0; v.b0 = b0; v.t0 = TAG_W'(t0);
      v.d1 = d1; v.b1 = b1; v.t1 = TAG_W'(t1);
      return v;
   endfunction

   task automatic check_port(input string name, input int k,
                             input logic [XLEN-1:0] ed, input logic eb,
                             input logic [TAG_W-1:0] et);
      logic [XLEN-1:0]  ad;
      logic             ab;
      logic [TAG_W-1:0] at;
      ad = rd_data[k*XLEN +: XLEN];
      ab = rd_busy[k];
      at = rd_tag[k*TAG_W +: TAG_W];
      checks++;
      if (ad !== ed || ab !== eb || at !== et) begin
         failures++;
         $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, want data=%h busy=%b tag=%h",
                  name, k, ad, ab, at, ed, eb, et);
      end
   endtask

   task automatic idle_inputs();
      rdy = 1'b1; flush = 1'b0;
      issue_en = 1'b0; issue_rd = '0; issue_tag = '0;
      commit_en = 1'b0; commit_rd = '0; commit_tag = '0; commit_data = '0;
   endtask

   task automatic set_reads(input int a0, input int a1);
      rd_addr = {AW'(a1), AW'(a0)};
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      idle_inputs();
      set_reads(3, 4);

      // rdy flush ie ird itag ce crd ctag cdata a0 a1 | d0 b0 t0 | d1 b1 t1
      vecs.push_back(mk(1,0, 0,0,0, 0,0,0,32'h0,        0,1,   32'h0,0,0,        32'h0,0,0));
      vecs.push_back(mk(1,0, 1,5,3, 0,0,0,32'h0,        5,5,   32'h0,0,0,        32'h0,0,0));
      vecs.push_back(mk(1,0, 0,0,0, 0,0,0,32'h0,        5,5,   32'h0,1,3,        32'h0,1,3));
      vecs.push_back(mk(1,0, 1,6,2, 0,0,0,32'h0,        6,5,   32'h0,0,0,        32'h0,1,3));
      vecs.push_back(mk(1,0, 1,6,9, 0,0,0,32'h0,        6,6,   32'h0,1,2,        32'h0,1,2));
      vecs.push_back(mk(1,0, 0,0,0, 1,6,2,32'h11,       6,6,   32'h0,1,9,        32'h0,1,9));
      vecs.push_back(mk(1,0, 0,0,0, 0,0,0,32'h0,        6,6,   32'h11,1,9,       32'h11,1,9));
      vecs.push_back(mk(1,0, 0,0,0, 1,6,9,32'h22,       6,0,   32'h22,0,0,       32'h0,0,0));
      vecs.push_back(mk(1,0, 1,7,4, 0,0,0,32'h0,        6,7,   32'h22,0,0,       32'h0,0,0));
      vecs.push_back(mk(1,0, 0,0,0, 1,7,4,32'hABCD,     5,7,   32'h0,1,3,        32'hABCD,0,0));
      vecs.push_back(mk(1,0, 1,8,1, 0,0,0,32'h0,        8,7,   32'h0,0,0,        32'hABCD,0,0));
      vecs.push_back(mk(1,1, 1,9,5, 1,8,1,32'h55,       8,9,   32'h55,0,0,       32'h0,0,0));
      vecs.push_back(mk(1,0, 0,0,0, 0,0,0,32'h0,        8,9,   32'h55,0,0,       32'h0,0,0));
      vecs.push_back(mk(1,0, 0,0,0, 0,0,0,32'h0,        5,7,   32'h0,0,0,        32'hABCD,0,0));
      vecs.push_back(mk(1,0, 1,0,6, 1,0,0,32'hFFFF,     0,0,   32'h0,0,0,        32'h0,0,0));
      vecs.push_back(mk(1,0, 0,0,0, 0,0,0,32'h0,        0,0,   32'h0,0,0,        32'h0,0,0));
      vecs.push_back(mk(0,0, 0,0,0, 1,10,0,32'h77,      10,10, 32'h77,0,0,       32'h77,0,0));
      vecs.push_back(mk(1,0, 0,0,0, 0,0,0,32'h0,        10,3,  32'h0,0,0,        32'h0,0,0));
      vecs.push_back(mk(0,0, 1,11,2, 0,0,0,32'h0,       11,11, 32'h0,0,0,        32'h0,0,0));
      vecs.push_back(mk(1,0, 0,0,0, 0,0,0,32'h0,        11,0,  32'h0,0,0,        32'h0,0,0));
      vecs.push_back(mk(1,0, 1,12,3, 0,0,0,32'h0,       12,12, 32'h0,0,0,        32'h0,0,0));
      vecs.push_back(mk(1,0, 1,12,5, 1,12,3,32'h99,     12,12, 32'h99,0,0,       32'h99,0,0));
      vecs.push_back(mk(1,0, 0,0,0, 0,0,0,32'h0,        12,0,  32'h99,1,5,       32'h0,0,0));
      vecs.push_back(mk(1,0, 0,0,0, 1,13,7,32'h1234,    13,12, 32'h1234,0,0,     32'h99,1,5));
      vecs.push_back(mk(1,0, 0,0,0, 0,0,0,32'h0,        13,13, 32'h1234,0,0,     32'h1234,0,0));

      // Reset state while rst is held.
      #1;
      check_port("reset_state", 0, '0, 1'b0, '0);
      check_port("reset_state", 1, '0, 1'b0, '0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rdy = vecs[i].rdy; flush = vecs[i].flush;
         issue_en = vecs[i].ie; issue_rd = vecs[i].ird; issue_tag = vecs[i].itag;
         commit_en = vecs[i].ce; commit_rd = vecs[i].crd; commit_tag = vecs[i].ctag;
         commit_data = vecs[i].cdata;
         rd_addr = {vecs[i].a1, vecs[i].a0};
         #1;
         $display("vec %0d: rdy=%b flush=%b issue=%b/x%0d/t%0d commit=%b/x%0d/t%0d/%h read x%0d x%0d",
                  i, vecs[i].rdy, vecs[i].flush, vecs[i].ie, vecs[i].ird, vecs[i].itag,
                  vecs[i].ce, vecs[i].crd, vecs[i].ctag, vecs[i].cdata, vecs[i].a0, vecs[i].a1);
         check_port($sformatf("vec%0d", i), 0, vecs[i].d0, vecs[i].b0, vecs[i].t0);
         check_port($sformatf("vec%0d", i), 1, vecs[i].d1, vecs[i].b1, vecs[i].t1);
      end

      // Asynchronous reset in the middle of a cycle.
      @(negedge clk);
      idle_inputs();
      commit_en = 1'b1; commit_rd = 5'd3; commit_tag = 4'd0; commit_data = 32'hDEADBEEF;
      issue_en = 1'b1; issue_rd = 5'd4; issue_tag = 4'd7;
      set_reads(0, 0);
      @(negedge clk);
      idle_inputs();
      set_reads(3, 4);
      #1;
      $display("seq reset_mid_run: before reset");
      check_port("pre_reset", 0, 32'hDEADBEEF, 1'b0, '0);
      check_port("pre_reset", 1, '0, 1'b1, 4'd7);
      #1;
      rst = 1'b1;
      #1;
      $display("seq reset_mid_run: rst asserted mid-cycle");
      check_port("async_reset", 0, '0, 1'b0, '0);
      check_port("async_reset", 1, '0, 1'b0, '0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      #1;
      $display("seq reset_mid_run: after release");
      check_port("post_reset", 0, '0, 1'b0, '0);
      check_port("post_reset", 1, '0, 1'b0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
